debug_ocimem_engine: RTL and testbench

Clock-domain consumer of the JTAG debug module's sysclk-side outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a). It owns the on-chip debug RAM, the monitor address register and the monitor data register. It executes JTAG-issued address-load, write and read commands with auto-increment. It returns MonDReg, monitor_ready and monitor_error to the JTAG debug module. A CPU-side slave port shares the RAM, with JTAG given priority.

---
 rtl/debug_ocimem_engine.sv | 144 ++++++++++++++
 tb/tb_debug_ocimem_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debug_ocimem_engine.sv
// Debug on-chip memory engine: executes JTAG address/write/read commands
// against the debug RAM and arbitrates a CPU slave port onto the same RAM.
// The JTAG side always wins the single RAM port.
module debug_ocimem_engine #(
  parameter int   ADDR_W     = 8,
  parameter logic INIT_READY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we, ram_re;

  logic rd_noinc;     // current read came from ocimem_a: leave MonAReg alone
  logic cpu_rd_pend;  // CPU read address issued last cycle, data phase now

  logic is_idle, any_strobe, multi_strobe;
  logic do_a, do_b, do_n;
  logic cpu_wr_go, cpu_rd_go;

  // jdo[2:0] and jdo[37:36] carry nothing for this engine
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign is_idle      = (state == IDLE);
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);

  // Priority a > b > no_action; strobes only execute in IDLE
  assign do_a = is_idle & take_action_ocimem_a;
  assign do_b = is_idle & take_action_ocimem_b & ~take_action_ocimem_a;
  assign do_n = is_idle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

  assign cpu_waitrequest = ~is_idle | any_strobe | (cpu_read & ~cpu_rd_pend);
  assign cpu_wr_go       = cpu_write & ~cpu_waitrequest;
  assign cpu_rd_go       = is_idle & ~any_strobe & cpu_read & ~cpu_rd_pend;

  // The RAM read register doubles as the CPU read data path
  assign cpu_readdata = ram_q;

  // Single RAM port mux: JTAG read/write first, then CPU
  always_comb begin
    ram_addr  = cpu_address;
    ram_wdata = cpu_writedata;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (state == RD_ISSUE) begin
      ram_addr = MonAReg;
      ram_re   = 1'b1;
    end else if (do_b) begin
      ram_addr  = MonAReg;
      ram_wdata = jdo[34:3];
      ram_we    = 1'b1;
    end else if (cpu_wr_go) begin
      ram_we = 1'b1;
    end else if (cpu_rd_go) begin
      ram_re = 1'b1;
    end
  end

  // RAM array write (contents are never reset)
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // RAM read register, 1-cycle latency
  always_ff @(posedge clk) begin
    if (reset)       ram_q <= '0;
    else if (ram_re) ram_q <= mem[ram_addr];
  end

  // JTAG read sequencer next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if ((do_a & jdo[35]) | do_n) state_nxt = RD_ISSUE;
      RD_ISSUE:   state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Monitor registers, error flag and CPU read tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= INIT_READY;
      monitor_error <= 1'b0;
      rd_noinc      <= 1'b0;
      cpu_rd_pend   <= 1'b0;
    end else begin
      state         <= state_nxt;
      monitor_ready <= (state_nxt == IDLE);
      cpu_rd_pend   <= cpu_rd_go;

      if (do_a) begin
        MonAReg  <= jdo[17 +: ADDR_W];
        rd_noinc <= 1'b1;
      end
      if (do_n) rd_noinc <= 1'b0;
      if (do_b) MonAReg <= MonAReg + ONE;

      if (state == RD_CAPTURE) begin
        MonDReg <= ram_q;
        if (!rd_noinc) MonAReg <= MonAReg + ONE;
      end

      // Clear wins over a collision flagged in the same cycle
      if (do_a & jdo[34])
        monitor_error <= 1'b0;
      else if ((is_idle & multi_strobe) | (~is_idle & any_strobe))
        monitor_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_ocimem_engine.sv
// Directed bench for debug_ocimem_engine: JTAG load/write/read, wrap,
// collisions, CPU arbitration and reset during a read.
module tb_debug_ocimem_engine;

  logic        clk, reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_n;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready, monitor_error;

  int n_cmp = 0;
  int n_err = 0;

  debug_ocimem_engine #(.ADDR_W(8), .INIT_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_n),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jcmd(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[17 +: 8] = addr;
    j[35] = rd;
    j[34] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdat(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One-cycle strobe; returns one cycle after the strobe edge
  task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] j);
    take_a = a; take_b = b; take_n = n; jdo = j;
    cyc();
    take_a = 0; take_b = 0; take_n = 0; jdo = '0;
  endtask

  initial begin
    reset = 1; jdo = '0; take_a = 0; take_b = 0; take_n = 0;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
    cyc(); cyc();
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_monareg", {24'h0, MonAReg}, 32'h0);
    chk("rst_ready", {31'h0, monitor_ready}, 32'h1);
    chk("rst_error", {31'h0, monitor_error}, 32'h0);
    chk("rst_cpu_rdata", cpu_readdata, 32'h0);
    chk("rst_waitreq", {31'h0, cpu_waitrequest}, 32'h0);
    reset = 0;
    cyc();

    // 1: address load then three writes
    strobe(1, 0, 0, jcmd(8'h10, 0, 0));
    chk("t1_addr_load", {24'h0, MonAReg}, 32'h10);
    strobe(0, 1, 0, jdat(32'hA));
    strobe(0, 1, 0, jdat(32'hB));
    strobe(0, 1, 0, jdat(32'hC));
    chk("t1_addr_inc", {24'h0, MonAReg}, 32'h13);
    chk("t1_error", {31'h0, monitor_error}, 32'h0);
    chk("t1_ready", {31'h0, monitor_ready}, 32'h1);

    // 2: ocimem_a-initiated read, then two no_action reads
    strobe(1, 0, 0, jcmd(8'h10, 1, 0));
    chk("t2_ready_n1", {31'h0, monitor_ready}, 32'h0);
    cyc();
    chk("t2_ready_n2", {31'h0, monitor_ready}, 32'h0);
    cyc();
    chk("t2_ready_n3", {31'h0, monitor_ready}, 32'h1);
    chk("t2_data_a", MonDReg, 32'hA);
    chk("t2_addr_noinc", {24'h0, MonAReg}, 32'h10);
    strobe(0, 0, 1, '0); cyc(); cyc();
    chk("t2_rd1_data", MonDReg, 32'hA);
    chk("t2_rd1_addr", {24'h0, MonAReg}, 32'h11);
    strobe(0, 0, 1, '0); cyc(); cyc();
    chk("t2_rd2_data", MonDReg, 32'hB);
    chk("t2_rd2_addr", {24'h0, MonAReg}, 32'h12);
    strobe(0, 0, 1, '0); cyc(); cyc();
    chk("t2_rd3_data", MonDReg, 32'hC);

    // 3: wrap at top of RAM
    strobe(1, 0, 0, jcmd(8'hFF, 0, 0));
    strobe(0, 1, 0, jdat(32'h55));
    chk("t3_wr_wrap", {24'h0, MonAReg}, 32'h00);
    strobe(1, 0, 0, jcmd(8'hFF, 1, 0)); cyc(); cyc();
    chk("t3_rd_ff", MonDReg, 32'h55);
    chk("t3_rd_ff_addr", {24'h0, MonAReg}, 32'hFF);
    strobe(0, 0, 1, '0); cyc(); cyc();
    chk("t3_rd_wrap_data", MonDReg, 32'h55);
    chk("t3_rd_wrap_addr", {24'h0, MonAReg}, 32'h00);

    // 4: collisions
    strobe(1, 0, 0, jcmd(8'h10, 0, 0));
    strobe(0, 0, 1, '0);
    strobe(0, 0, 1, '0);
    cyc();
    chk("t4_busy_data", MonDReg, 32'hA);
    chk("t4_busy_addr", {24'h0, MonAReg}, 32'h11);
    chk("t4_busy_error", {31'h0, monitor_error}, 32'h1);
    strobe(1, 0, 0, jcmd(8'h11, 0, 1));
    chk("t4_clear_error", {31'h0, monitor_error}, 32'h0);
    strobe(1, 1, 0, jcmd(8'h30, 0, 0));
    chk("t4_simul_addr", {24'h0, MonAReg}, 32'h30);
    chk("t4_simul_error", {31'h0, monitor_error}, 32'h1);
    strobe(1, 0, 0, jcmd(8'h11, 1, 1)); cyc(); cyc();
    chk("t4_no_write", MonDReg, 32'hB);
    chk("t4_clr_rd_error", {31'h0, monitor_error}, 32'h0);

    // 5: CPU write then read
    cpu_write = 1; cpu_address = 8'h20; cpu_writedata = 32'h1234; #1;
    chk("t5_wr_wait", {31'h0, cpu_waitrequest}, 32'h0);
    cyc();
    cpu_write = 0; cpu_read = 1; #1;
    chk("t5_rd_c1_wait", {31'h0, cpu_waitrequest}, 32'h1);
    cyc();
    chk("t5_rd_c2_wait", {31'h0, cpu_waitrequest}, 32'h0);
    chk("t5_rd_c2_data", cpu_readdata, 32'h1234);
    cpu_read = 0;
    cyc();

    // 5b: JTAG read lands on the CPU data phase
    strobe(1, 0, 0, jcmd(8'h11, 0, 0));
    cpu_read = 1; #1;
    chk("t5b_c1_wait", {31'h0, cpu_waitrequest}, 32'h1);
    cyc();
    take_n = 1; #1;
    chk("t5b_strobe_wait", {31'h0, cpu_waitrequest}, 32'h1);
    cyc();
    take_n = 0; #1;
    chk("t5b_issue_wait", {31'h0, cpu_waitrequest}, 32'h1);
    cyc();
    chk("t5b_capture_wait", {31'h0, cpu_waitrequest}, 32'h1);
    cyc();
    chk("t5b_restart_wait", {31'h0, cpu_waitrequest}, 32'h1);
    chk("t5b_jtag_data", MonDReg, 32'hB);
    cyc();
    chk("t5b_done_wait", {31'h0, cpu_waitrequest}, 32'h0);
    chk("t5b_done_data", cpu_readdata, 32'h1234);
    cpu_read = 0;
    cyc();

    // 6: reset while in RD_CAPTURE, with the error flag set
    strobe(1, 0, 0, jcmd(8'h10, 1, 0));
    strobe(0, 0, 1, '0);
    reset = 1;
    cyc();
    reset = 0; #1;
    chk("t6_mondreg", MonDReg, 32'h0);
    chk("t6_monareg", {24'h0, MonAReg}, 32'h0);
    chk("t6_ready", {31'h0, monitor_ready}, 32'h1);
    chk("t6_error", {31'h0, monitor_error}, 32'h0);
    chk("t6_waitreq", {31'h0, cpu_waitrequest}, 32'h0);
    cyc(); cyc();
    chk("t6_stays_idle", {31'h0, monitor_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
